imm_scan_ctrl: RTL
==================

// Module: imm_scan_ctrl
// PURPOSE
//  Frame-scan controller for the imm pixel-masking datapath. On start it walks the image in raster order,
//  fetches each pixel from a sync frame RAM and drives imm with pixel, coordinates, latched offsets and Tx.
//  It then emits imm's pixel_result on a valid/ready output stream. Sits between frame buffer and output writer.
// PARAMETERS
//  PIX_W   12   pixel width (imm pixel/pixel_result)
//  I_W     9    column coordinate width (imm i_p/i_offset)
//  J_W     8    row coordinate width (imm j_p/j_offset)
//  IMG_W   320  columns per frame (i range 0..IMG_W-1)
//  IMG_H   240  rows per frame (j range 0..IMG_H-1)
//  ADDR_W  17   frame RAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       begin frame; sampled only in IDLE
//  abort        in   1       cancel frame; any state -> IDLE next cycle
//  cfg_i_off    in   I_W     column offset; latched on accepted start
//  cfg_j_off    in   J_W     row offset; latched on accepted start
//  cfg_tx       in   1       mask mode; latched on accepted start
//  busy         out  1       high from cycle after accepted start through DONE
//  done         out  1       one-cycle pulse after last pixel transferred
//  rd_en        out  1       frame RAM read strobe
//  rd_addr      out  ADDR_W  j*IMG_W + i
//  rd_data      in   PIX_W   RAM data, valid exactly 1 cycle after rd_en
//  imm_pixel    out  PIX_W   registered pixel to imm
//  imm_i_p      out  I_W     current column
//  imm_j_p      out  J_W     current row
//  imm_i_offset out  I_W     latched cfg_i_off
//  imm_j_offset out  J_W     latched cfg_j_off
//  imm_tx       out  1       latched cfg_tx
//  imm_result   in   PIX_W   combinational imm pixel_result
//  out_pixel    out  PIX_W   = imm_result while out_valid
//  out_valid    out  1       output pixel available
//  out_ready    in   1       downstream accept; transfer = out_valid & out_ready
//  stall_cnt    out  16      perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, out_valid = 0; i, j, rd_addr, imm_pixel, latched cfg, stall_cnt = 0.
//  FSM: IDLE -(start)-> RD -> CAP -> OUT -(transfer & !last)-> RD; OUT -(transfer & last)-> DONE -> IDLE.
//  RD: rd_en=1, rd_addr=j*IMG_W+i. CAP: imm_pixel <= rd_data. OUT: out_valid=1, hold until out_ready.
//  Latency: start sampled cycle 0 -> rd_en cycle 1 -> out_valid cycle 2 later (cycle 3); 3 cycles/pixel at ready=1.
//  All imm_* outputs are registered and stay stable through OUT until transfer (no glitch under backpressure).
//  Coordinates advance only on transfer: i+1; i==IMG_W-1 -> i=0, j+1; last = (i==IMG_W-1 && j==IMG_H-1).
//  rd_addr kept as a running counter (+1 per pixel), not a multiplier; reset to 0 on accepted start.
//  start while busy ignored; cfg_* changes mid-frame not visible until next accepted start.
//  abort has priority over transfer and start in the same cycle: -> IDLE, out_valid=0, no done, i=j=0.
//  Async reset mid-frame: immediately to reset values; no done.
// CONFIGURATION
//  IMM_CTRL_PERF_EN defined: stall_cnt counts cycles with out_valid & !out_ready, saturates at 16'hFFFF,
//   cleared on accepted start. Not defined: stall_cnt tied to 0, no counter logic.
// STRUCTURE
//  imm_defs.vh: PIX_W/I_W/J_W defaults, IMG_W/IMG_H, ADDR_W, FSM state encodings (shared with imm and bench).
//  Sub-module imm_scan_cnt: raster i/j/address counter with inc, clear, last outputs.
// TESTING (IMG_W=4, IMG_H=3, ADDR_W=4)
//  1 Reset: rst_n=0 mid-OUT -> same-cycle busy=0, out_valid=0, rd_en=0, done never pulses.
//  2 Frame, out_ready=1: start @0 -> rd_addr 0..11 at cycles 1,4,..,34; 12 transfers; done=1 only @37.
//  3 Wrap: transfer at i=3,j=0 -> next rd_addr=4, imm_i_p=0, imm_j_p=1; after i=3,j=2 -> DONE.
//  4 Backpressure: out_ready=0 for 5 cycles on pixel 2 -> out_pixel/imm_* stable, no rd_en; stall_cnt=5 (PERF_EN).
//  5 Abort at pixel 6 in OUT with out_ready=1 -> IDLE next cycle, no transfer counted, no done; restart reads addr 0.
//  6 Config: start with i_off=5,j_off=7,tx=1; change cfg and pulse start mid-frame -> ignored, imm_* keep 5/7/1.

Source files
------------

// File: rtl/imm_scan_ctrl_pkg.sv
// rtl/imm_scan_ctrl_pkg.sv - shared geometry defaults and FSM encoding for the imm scan controller
//
// Purpose: single home for the imm datapath widths, default frame geometry
// and the scan FSM state encoding, so the controller, its raster counter
// and anything that models imm agree on the same values.
// Ports: none (package).
package imm_scan_ctrl_pkg;

    localparam int DEF_PIX_W  = 12;
    localparam int DEF_I_W    = 9;
    localparam int DEF_J_W    = 8;
    localparam int DEF_IMG_W  = 320;
    localparam int DEF_IMG_H  = 240;
    localparam int DEF_ADDR_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } scan_state_t;

endpackage

// File: rtl/imm_scan_cnt.sv
// rtl/imm_scan_cnt.sv - raster column/row/address counter for the frame scan
//
// Purpose: walks (i, j) in raster order and keeps the linear frame address as
// a running count alongside, so no j*IMG_W multiply is needed.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        return to pixel (0,0), address 0; wins over inc
//   inc          advance one pixel
//   i, j         current column / row
//   addr         current linear address (j*IMG_W + i)
//   last         current pixel is the final one of the frame
module imm_scan_cnt
    import imm_scan_ctrl_pkg::*;
#(
    parameter int I_W    = DEF_I_W,
    parameter int J_W    = DEF_J_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [I_W-1:0]    i,
    output logic [J_W-1:0]    j,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [I_W-1:0] I_MAX = I_W'(IMG_W - 1);
    localparam logic [J_W-1:0] J_MAX = J_W'(IMG_H - 1);

    logic i_end;

    assign i_end = (i == I_MAX);
    assign last  = i_end && (j == J_MAX);

    // Stepping past the last pixel folds straight back to the origin so the
    // counter is already parked at (0,0) when the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i    <= '0;
            j    <= '0;
            addr <= '0;
        end else if (clear || (inc && last)) begin
            i    <= '0;
            j    <= '0;
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            if (i_end) begin
                i <= '0;
                j <= j + 1'b1;
            end else begin
                i <= i + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imm_scan_ctrl.sv
// rtl/imm_scan_ctrl.sv - frame-scan controller feeding the imm pixel-masking datapath
//
// Purpose: on start, walks the frame in raster order, reads each pixel from a
// synchronous frame RAM, presents it with coordinates and latched offsets/Tx
// to imm, and emits imm's result on a valid/ready output stream.
// Build option: define IMM_CTRL_PERF_EN to enable the stall_cnt counter;
// otherwise stall_cnt is tied to zero.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               begin frame (IDLE only) / cancel frame (any state)
//   cfg_i_off, cfg_j_off, cfg_tx  offsets and mask mode, latched on accepted start
//   busy, done                 frame in progress / one-cycle completion pulse
//   rd_en, rd_addr, rd_data    frame RAM read port (data one cycle after rd_en)
//   imm_pixel .. imm_tx        registered operands driven to imm
//   imm_result                 imm's combinational result
//   out_pixel, out_valid, out_ready  output pixel stream
//   stall_cnt                  cycles spent waiting on out_ready
module imm_scan_ctrl
    import imm_scan_ctrl_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int I_W    = DEF_I_W,
    parameter int J_W    = DEF_J_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [I_W-1:0]    cfg_i_off,
    input  logic [J_W-1:0]    cfg_j_off,
    input  logic              cfg_tx,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  imm_pixel,
    output logic [I_W-1:0]    imm_i_p,
    output logic [J_W-1:0]    imm_j_p,
    output logic [I_W-1:0]    imm_i_offset,
    output logic [J_W-1:0]    imm_j_offset,
    output logic              imm_tx,
    input  logic [PIX_W-1:0]  imm_result,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       stall_cnt
);

    scan_state_t state, state_nxt;

    logic accept_start;
    logic xfer;
    logic cnt_last;

    // abort outranks both start and a same-cycle transfer
    assign accept_start = (state == ST_IDLE) && start && !abort;
    assign xfer         = (state == ST_OUT) && out_ready && !abort;

    imm_scan_cnt #(
        .I_W    (I_W),
        .J_W    (J_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept_start || abort),
        .inc   (xfer),
        .i     (imm_i_p),
        .j     (imm_j_p),
        .addr  (rd_addr),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_RD;
                ST_RD:   state_nxt = ST_CAP;
                ST_CAP:  state_nxt = ST_OUT;
                ST_OUT:  if (out_ready) state_nxt = cnt_last ? ST_DONE : ST_RD;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        rd_en     = (state == ST_RD);
        out_valid = (state == ST_OUT);
    end

    // Pixel and config are held in registers so imm sees steady operands for
    // the whole OUT phase, however long downstream backpressure lasts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_pixel <= '0;
        end else if (state == ST_CAP) begin
            imm_pixel <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_i_offset <= '0;
            imm_j_offset <= '0;
            imm_tx       <= 1'b0;
        end else if (accept_start) begin
            imm_i_offset <= cfg_i_off;
            imm_j_offset <= cfg_j_off;
            imm_tx       <= cfg_tx;
        end
    end

    assign out_pixel = out_valid ? imm_result : '0;

`ifdef IMM_CTRL_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
